// File: rtl/daq_frame_reader.sv
// Waits for a BUSY fall, then reads every channel of ADC_COUNT shared-bus ADCs into a FIFO as one packet (header + samples).
// Header appears 2 cycles after BUSY is first sampled low; a full FIFO drops words (ovf_o) and never stalls the ADC read.
module daq_frame_reader #(
  parameter int ADC_COUNT   = 1,
  parameter int CH_PER_ADC  = 8,
  parameter int DATA_W      = 16,
  parameter int RD_LOW_CYC  = 3,
  parameter int RD_HIGH_CYC = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 en_i,
  input  logic                 busy_i,
  input  logic                 frstdata_i,
  input  logic [DATA_W-1:0]    db_i,
  output logic                 rd_n_o,
  output logic [ADC_COUNT-1:0] cs_n_o,
  output logic [DATA_W-1:0]    fifo_data_o,
  output logic                 fifo_wrreq_o,
  input  logic                 fifo_wrfull_i,
  output logic                 frame_done_o,
  output logic [7:0]           seq_o,
  output logic                 ovf_o,
  output logic                 frst_err_o,
  output logic                 miss_o
);

  typedef enum logic [2:0] {IDLE, HEADER, CS_SETUP, RD_LOW, RD_HIGH, CS_GAP, DONE} state_t;

  localparam logic [7:0] RD_LOW_LAST  = 8'(RD_LOW_CYC - 1);
  localparam logic [7:0] RD_HIGH_LAST = 8'(RD_HIGH_CYC - 1);
  localparam logic [2:0] CH_LAST      = 3'(CH_PER_ADC - 1);
  localparam logic [1:0] ADC_LAST     = 2'(ADC_COUNT - 1);

  state_t             state;
  logic               busy_s1, busy_s2, busy_fall;
  logic [7:0]         cyc_cnt;
  logic [2:0]         ch_cnt;
  logic [1:0]         adc_cnt;
  logic [7:0]         seq_cnt;
  logic               wr_pend;
  logic [DATA_W-1:0]  hdr_word;

  function automatic logic [ADC_COUNT-1:0] cs_sel(input logic [1:0] a);
    return ~(ADC_COUNT'(1) << a);
  endfunction

  always_comb begin
    hdr_word                 = '0;
    hdr_word[DATA_W-1 -: 8]  = 8'hA5;
    hdr_word[7:0]            = seq_cnt;
  end

  // The fall pulse is registered so the FSM never acts on a combinational edge term.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_s1   <= 1'b0;
      busy_s2   <= 1'b0;
      busy_fall <= 1'b0;
    end else begin
      busy_s1   <= busy_i;
      busy_s2   <= busy_s1;
      busy_fall <= busy_s2 & ~busy_s1;
    end
  end

  // Full is judged in the write cycle itself, so a dropped word never reaches the FIFO.
  assign fifo_wrreq_o = wr_pend & ~fifo_wrfull_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      rd_n_o       <= 1'b1;
      cs_n_o       <= '1;
      fifo_data_o  <= '0;
      wr_pend      <= 1'b0;
      frame_done_o <= 1'b0;
      seq_o        <= '0;
      seq_cnt      <= '0;
      ovf_o        <= 1'b0;
      frst_err_o   <= 1'b0;
      miss_o       <= 1'b0;
      cyc_cnt      <= '0;
      ch_cnt       <= '0;
      adc_cnt      <= '0;
    end else begin
      wr_pend      <= 1'b0;
      frame_done_o <= 1'b0;
      if (wr_pend && fifo_wrfull_i) ovf_o <= 1'b1;
      if (busy_fall && state != IDLE) miss_o <= 1'b1;

      case (state)
        IDLE: begin
          if (busy_fall && en_i) begin
            state       <= HEADER;
            fifo_data_o <= hdr_word;
            wr_pend     <= 1'b1;
            seq_o       <= seq_cnt;
            seq_cnt     <= seq_cnt + 8'd1;
            adc_cnt     <= '0;
          end
        end
        HEADER: begin
          state  <= CS_SETUP;
          cs_n_o <= cs_sel(adc_cnt);
        end
        CS_SETUP: begin
          state   <= RD_LOW;
          rd_n_o  <= 1'b0;
          cyc_cnt <= '0;
          ch_cnt  <= '0;
        end
        RD_LOW: begin
          if (cyc_cnt == RD_LOW_LAST) begin
            state       <= RD_HIGH;
            rd_n_o      <= 1'b1;
            cyc_cnt     <= '0;
            fifo_data_o <= db_i;
            wr_pend     <= 1'b1;
            if (frstdata_i != (ch_cnt == '0)) frst_err_o <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        RD_HIGH: begin
          if (cyc_cnt == RD_HIGH_LAST) begin
            cyc_cnt <= '0;
            if (ch_cnt == CH_LAST) begin
              state  <= CS_GAP;
              cs_n_o <= '1;
            end else begin
              state  <= RD_LOW;
              rd_n_o <= 1'b0;
              ch_cnt <= ch_cnt + 3'd1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        CS_GAP: begin
          if (adc_cnt == ADC_LAST) begin
            state        <= DONE;
            frame_done_o <= 1'b1;
          end else begin
            state   <= CS_SETUP;
            adc_cnt <= adc_cnt + 2'd1;
            cs_n_o  <= cs_sel(adc_cnt + 2'd1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
